// File: rtl/rcv_controller.sv
// Receive control FSM for the USB full-speed receiver: gates the bit timer, checks sync,
// strobes one FIFO write per data byte and validates EOP framing and the byte limit.
module rcv_controller #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               d_edge,
    input  logic                               eop,
    input  logic                               shift_enable,
    input  logic                               byte_received,
    input  logic [7:0]                         rcv_data,
    output logic                               rcving,
    output logic                               w_enable,
    output logic                               r_error,
    output logic                               pkt_done,
    output logic [$clog2(MAX_BYTES+1)-1:0]     byte_cnt
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        SYNC_CHK,
        RX_BYTE,
        STORE,
        EOP2,
        EOP_J,
        DONE,
        ERR_WAIT,
        ERR_EOP2,
        ERR_IDLE
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
    logic           sampleSe0;
    logic           sampleBit;

    assign sampleSe0 = shift_enable & eop;
    assign sampleBit = shift_enable & ~eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // SE0 samples are tested before byte_received so a line reset always wins.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;

        unique case (state_q)
            IDLE, ERR_IDLE: begin
                if (d_edge) begin
                    state_d    = SYNC_WAIT;
                    byte_cnt_d = '0;
                end
            end
            SYNC_WAIT: begin
                if (sampleSe0)          state_d = ERR_EOP2;
                else if (byte_received) state_d = SYNC_CHK;
            end
            SYNC_CHK: begin
                bit_cnt_d = '0;
                state_d   = (rcv_data == SYNC_BYTE) ? RX_BYTE : ERR_WAIT;
            end
            RX_BYTE: begin
                if (sampleSe0) begin
                    state_d = (bit_cnt_q == 3'd0) ? EOP2 : ERR_EOP2;
                end else if (byte_received) begin
                    state_d = (byte_cnt_q == MAX_CNT) ? ERR_WAIT : STORE;
                end
                if (sampleBit) bit_cnt_d = bit_cnt_q + 3'd1;
            end
            STORE: begin
                byte_cnt_d = byte_cnt_q + CW'(1);
                state_d    = RX_BYTE;
                if (sampleBit) bit_cnt_d = bit_cnt_q + 3'd1;
            end
            EOP2: begin
                if (sampleSe0)      state_d = EOP_J;
                else if (sampleBit) state_d = ERR_WAIT;
            end
            EOP_J: begin
                if (sampleBit)      state_d = DONE;
                else if (sampleSe0) state_d = ERR_WAIT;
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR_WAIT: begin
                if (sampleSe0) state_d = ERR_EOP2;
            end
            ERR_EOP2: begin
                if (sampleBit) state_d = ERR_IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rcving   = state_q inside {SYNC_WAIT, SYNC_CHK, RX_BYTE, STORE, EOP2, EOP_J,
                                      ERR_WAIT, ERR_EOP2};
    assign w_enable = (state_q == STORE);
    assign pkt_done = (state_q == DONE);
    assign r_error  = state_q inside {ERR_WAIT, ERR_EOP2, ERR_IDLE};
    assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_rcv_controller.sv
// Scoreboard bench for rcv_controller: two instances (64-byte and 2-byte limits) share
// one randomized line stream; a packet-level model predicts writes, completion and errors.
module tb_rcv_controller;

    logic       clk;
    logic       rst;
    logic       dEdge;
    logic       eop;
    logic       shiftEnable;
    logic       byteReceived;
    logic [7:0] rcvData;

    logic       rcvingA, wEnA, rErrA, doneA;
    logic [6:0] byteCntA;
    logic       rcvingB, wEnB, rErrB, doneB;
    logic [1:0] byteCntB;

    int         nCompared;
    int         nMismatched;
    logic [7:0] pktData[$];
    logic [7:0] wrQA[$];
    logic [7:0] wrQB[$];
    int         doneExpA;
    int         doneExpB;
    int         expCntA, expCntB;
    bit         expErrA, expErrB;

    rcv_controller #(.SYNC_BYTE(8'h80), .MAX_BYTES(64)) dutA (
        .clk(clk), .rst(rst), .d_edge(dEdge), .eop(eop), .shift_enable(shiftEnable),
        .byte_received(byteReceived), .rcv_data(rcvData), .rcving(rcvingA),
        .w_enable(wEnA), .r_error(rErrA), .pkt_done(doneA), .byte_cnt(byteCntA)
    );

    rcv_controller #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dutB (
        .clk(clk), .rst(rst), .d_edge(dEdge), .eop(eop), .shift_enable(shiftEnable),
        .byte_received(byteReceived), .rcv_data(rcvData), .rcving(rcvingB),
        .w_enable(wEnB), .r_error(rErrB), .pkt_done(doneB), .byte_cnt(byteCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted byte; every pkt_done must be owed.
    always @(negedge clk) begin
        if (wEnA) begin
            if (wrQA.size() > 0) checkOutput("wrDataA", int'(rcvData), int'(wrQA.pop_front()));
            else begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL wrExtraA: got write of %0d, required none", rcvData);
            end
        end
        if (wEnB) begin
            if (wrQB.size() > 0) checkOutput("wrDataB", int'(rcvData), int'(wrQB.pop_front()));
            else begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL wrExtraB: got write of %0d, required none", rcvData);
            end
        end
        if (doneA) begin
            if (doneExpA > 0) begin doneExpA--; nCompared++; end
            else begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL doneExtraA: got pkt_done, required none");
            end
        end
        if (doneB) begin
            if (doneExpB > 0) begin doneExpB--; nCompared++; end
            else begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL doneExtraB: got pkt_done, required none");
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input logic se0, input logic endOfByte, input logic [7:0] data);
        eop         = se0;
        shiftEnable = 1'b1;
        cyc();
        shiftEnable = 1'b0;
        if (endOfByte) begin
            rcvData      = data;
            byteReceived = 1'b1;
            cyc();
            byteReceived = 1'b0;
            repeat (6) cyc();
        end else begin
            repeat (7) cyc();
        end
    endtask

    task automatic sendByte(input logic [7:0] data);
        for (int i = 0; i < 8; i++) sendBit(1'b0, i == 7, data);
    endtask

    task automatic sendBits(input int k);
        for (int i = 0; i < k; i++) sendBit(1'b0, 1'b0, 8'h00);
    endtask

    // Packet-level model: a bad start yields nothing; otherwise up to maxB bytes land and
    // any overflow, mid-byte SE0 or EOP other than exactly two SE0 bits marks an error.
    task automatic modelPacket(input logic [7:0] sync, input int n, input int k, input int se,
                               input bit early, input int maxB, output int nw, output bit err);
        if (early || sync != 8'h80) begin
            nw  = 0;
            err = 1'b1;
        end else begin
            nw  = (n > maxB) ? maxB : n;
            err = (n > maxB) || (k != 0) || (se != 2);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] sync, input int n, input int k,
                                 input int se, input bit early);
        int nwA, nwB;
        modelPacket(sync, n, k, se, early, 64, nwA, expErrA);
        modelPacket(sync, n, k, se, early, 2, nwB, expErrB);
        for (int i = 0; i < nwA; i++) wrQA.push_back(pktData[i]);
        for (int i = 0; i < nwB; i++) wrQB.push_back(pktData[i]);
        if (!expErrA) doneExpA++;
        if (!expErrB) doneExpB++;
        expCntA = nwA;
        expCntB = nwB;

        dEdge = 1'b1;
        cyc();
        dEdge = 1'b0;
        checkOutput("startErrA", int'(rErrA), 0);
        checkOutput("startErrB", int'(rErrB), 0);
        checkOutput("startRcvA", int'(rcvingA), 1);
        checkOutput("startRcvB", int'(rcvingB), 1);
        repeat (3) cyc();
        if (!early) begin
            sendByte(sync);
            for (int i = 0; i < n; i++) sendByte(pktData[i]);
            sendBits(k);
        end
        repeat (se) sendBit(1'b1, 1'b0, 8'h00);
        sendBit(1'b0, 1'b0, 8'h00);
        sendBit(1'b1, 1'b0, 8'h00);
        sendBit(1'b0, 1'b0, 8'h00);
        repeat (2) cyc();

        checkOutput("endRcvA", int'(rcvingA), 0);
        checkOutput("endRcvB", int'(rcvingB), 0);
        checkOutput("endErrA", int'(rErrA), int'(expErrA));
        checkOutput("endErrB", int'(rErrB), int'(expErrB));
        checkOutput("endCntA", int'(byteCntA), expCntA);
        checkOutput("endCntB", int'(byteCntB), expCntB);
        checkOutput("wrLeftA", wrQA.size(), 0);
        checkOutput("wrLeftB", wrQB.size(), 0);
        checkOutput("doneLeftA", doneExpA, 0);
        checkOutput("doneLeftB", doneExpB, 0);
        wrQA.delete();
        wrQB.delete();
        doneExpA = 0;
        doneExpB = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "RcvA"}, int'(rcvingA), 0);
        checkOutput({tag, "WenA"}, int'(wEnA), 0);
        checkOutput({tag, "ErrA"}, int'(rErrA), 0);
        checkOutput({tag, "DoneA"}, int'(doneA), 0);
        checkOutput({tag, "CntA"}, int'(byteCntA), 0);
        checkOutput({tag, "RcvB"}, int'(rcvingB), 0);
        checkOutput({tag, "ErrB"}, int'(rErrB), 0);
        checkOutput({tag, "CntB"}, int'(byteCntB), 0);
    endtask

    initial begin
        nCompared    = 0;
        nMismatched  = 0;
        doneExpA     = 0;
        doneExpB     = 0;
        rst          = 1'b1;
        dEdge        = 1'b0;
        eop          = 1'b0;
        shiftEnable  = 1'b0;
        byteReceived = 1'b0;
        rcvData      = 8'h00;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        checkAllZero("rst");

        pktData = '{8'hA5, 8'h3C};
        applyStimulus(8'h80, 2, 0, 2, 1'b0);
        applyStimulus(8'h81, 2, 0, 2, 1'b0);
        pktData = '{8'hA5};
        applyStimulus(8'h80, 1, 3, 2, 1'b0);
        pktData = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h80, 3, 0, 2, 1'b0);
        pktData.delete();
        applyStimulus(8'h80, 0, 0, 2, 1'b1);
        applyStimulus(8'h80, 0, 0, 2, 1'b0);
        pktData = '{8'h5A, 8'hC3};
        applyStimulus(8'h80, 2, 0, 1, 1'b0);
        applyStimulus(8'h80, 2, 0, 3, 1'b0);

        // Reset in the middle of the first data byte, then a clean packet.
        dEdge = 1'b1;
        cyc();
        dEdge = 1'b0;
        repeat (3) cyc();
        sendByte(8'h80);
        sendBits(4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkAllZero("midRst");
        pktData = '{8'h96, 8'h69};
        applyStimulus(8'h80, 2, 0, 2, 1'b0);

        pktData.delete();
        for (int i = 0; i < 65; i++) pktData.push_back(8'($urandom_range(0, 255)));
        applyStimulus(8'h80, 65, 0, 2, 1'b0);

        for (int p = 0; p < 24; p++) begin
            logic [7:0] sync;
            int n, k, se;
            bit early;
            early = ($urandom % 8) == 0;
            sync  = (($urandom % 5) == 0) ? 8'($urandom_range(0, 255)) : 8'h80;
            n     = $urandom_range(0, 4);
            k     = (($urandom % 4) == 0) ? $urandom_range(1, 7) : 0;
            se    = (($urandom % 5) == 0) ? ((($urandom % 2) == 0) ? 1 : 3) : 2;
            pktData.delete();
            for (int i = 0; i < n; i++) pktData.push_back(8'($urandom_range(0, 255)));
            applyStimulus(sync, n, k, se, early);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
